nfc_page_reader: RTL and testbench

NFC_PAGE_READER -- requirements
Module: nfc_page_reader

---
 rtl/nfc_page_reader.sv | 186 ++++++++++++++++++
 tb/tb_nfc_page_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nfc_page_reader.sv
// NAND page reader: issues a READ command with a three-cycle page address, waits out
// the array busy period, then streams PAGE_BYTES bytes through a valid/ready port.
module nfc_page_reader #(
    parameter int PAGE_BYTES = 512,
    parameter int BSY_TO     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] page,
    output logic       busy,
    output logic       done,
    output logic [7:0] f_io_out,
    output logic       f_io_oe,
    input  logic [7:0] f_io_in,
    output logic       f_cle,
    output logic       f_ale,
    output logic       f_wen,
    output logic       f_ren,
    input  logic       f_rb,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        ADDR     = 3'd2,
        WAIT_BSY = 3'd3,
        WAIT_RDY = 3'd4,
        READ     = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [8:0]  LAST_BYTE = 9'(PAGE_BYTES - 1);
    localparam logic [15:0] LAST_TO   = 16'(BSY_TO - 1);

    state_t      state_r;
    logic [8:0]  page_r;
    logic        busy_r;
    logic        done_r;
    logic [7:0]  io_out_r;
    logic        io_oe_r;
    logic        cle_r;
    logic        ale_r;
    logic        wen_r;
    logic        ren_r;
    logic [7:0]  data_r;
    logic        valid_r;
    logic [8:0]  byte_cnt_r;
    logic [1:0]  addr_idx_r;
    logic        rd_ph_r;
    logic [15:0] to_cnt_r;
    logic        xfer_s;
    logic        last_byte_s;

    assign xfer_s      = valid_r & out_ready;
    assign last_byte_s = (byte_cnt_r == LAST_BYTE);

    // Sequencer: flash bus cycles are paced by the wen/ren registers themselves,
    // so a low strobe is always the first clock of its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            page_r     <= 9'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            io_out_r   <= 8'h00;
            io_oe_r    <= 1'b0;
            cle_r      <= 1'b0;
            ale_r      <= 1'b0;
            wen_r      <= 1'b1;
            ren_r      <= 1'b1;
            data_r     <= 8'h00;
            valid_r    <= 1'b0;
            byte_cnt_r <= 9'd0;
            addr_idx_r <= 2'd0;
            rd_ph_r    <= 1'b0;
            to_cnt_r   <= 16'd0;
        end else begin
            done_r <= 1'b0;
            if (xfer_s) begin
                valid_r    <= 1'b0;
                byte_cnt_r <= byte_cnt_r + 9'd1;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        page_r     <= page;
                        busy_r     <= 1'b1;
                        byte_cnt_r <= 9'd0;
                        cle_r      <= 1'b1;
                        ale_r      <= 1'b0;
                        io_oe_r    <= 1'b1;
                        io_out_r   <= 8'h00;
                        wen_r      <= 1'b0;
                        state_r    <= CMD;
                    end
                end
                CMD: begin
                    if (!wen_r) begin
                        wen_r <= 1'b1;
                    end else begin
                        cle_r      <= 1'b0;
                        ale_r      <= 1'b1;
                        io_out_r   <= 8'h00;
                        wen_r      <= 1'b0;
                        addr_idx_r <= 2'd0;
                        state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (!wen_r) begin
                        wen_r <= 1'b1;
                    end else if (addr_idx_r == 2'd0) begin
                        addr_idx_r <= 2'd1;
                        io_out_r   <= page_r[7:0];
                        wen_r      <= 1'b0;
                    end else if (addr_idx_r == 2'd1) begin
                        addr_idx_r <= 2'd2;
                        io_out_r   <= {7'b0000000, page_r[8]};
                        wen_r      <= 1'b0;
                    end else begin
                        io_oe_r  <= 1'b0;
                        ale_r    <= 1'b0;
                        io_out_r <= 8'h00;
                        to_cnt_r <= 16'd0;
                        state_r  <= WAIT_BSY;
                    end
                end
                WAIT_BSY: begin
                    // A missed busy pulse means the data was ready before we looked.
                    if (!f_rb || (to_cnt_r == LAST_TO)) begin
                        state_r <= WAIT_RDY;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end
                WAIT_RDY: begin
                    if (f_rb) begin
                        ren_r   <= 1'b0;
                        rd_ph_r <= 1'b0;
                        state_r <= READ;
                    end
                end
                READ: begin
                    if (!ren_r) begin
                        if (!rd_ph_r) begin
                            rd_ph_r <= 1'b1;
                        end else begin
                            data_r  <= f_io_in;
                            valid_r <= 1'b1;
                            ren_r   <= 1'b1;
                        end
                    end else if (xfer_s && last_byte_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= DONE;
                    end else if (!valid_r || xfer_s) begin
                        ren_r   <= 1'b0;
                        rd_ph_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign f_io_out  = io_out_r;
    assign f_io_oe   = io_oe_r;
    assign f_cle     = cle_r;
    assign f_ale     = ale_r;
    assign f_wen     = wen_r;
    assign f_ren     = ren_r;
    assign out_data  = data_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_nfc_page_reader.sv
// Randomized bench for nfc_page_reader with a behavioural NAND + consumer model
// advanced once per falling clock edge from a single process.
module tb_nfc_page_reader;

    localparam int PAGE_BYTES = 512;
    localparam int BSY_TO     = 8;

    logic       clk = 1'b0;
    logic       rst, start, busy, done;
    logic [8:0] page;
    logic [7:0] f_io_out, f_io_in, out_data;
    logic       f_io_oe, f_cle, f_ale, f_wen, f_ren, f_rb, out_valid, out_ready;

    nfc_page_reader #(.PAGE_BYTES(PAGE_BYTES), .BSY_TO(BSY_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .page(page), .busy(busy), .done(done),
        .f_io_out(f_io_out), .f_io_oe(f_io_oe), .f_io_in(f_io_in), .f_cle(f_cle),
        .f_ale(f_ale), .f_wen(f_wen), .f_ren(f_ren), .f_rb(f_rb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int         cyc, col, flash_base;
    logic       prev_wen, prev_ren, hold_prev;
    logic [7:0] held;
    logic [9:0] wlog[$];
    logic [7:0] rx[$];
    int         rb_mode, rb_delay, rb_len, rb_timer, ready_mode, low_run;
    bit         addr_done, gap_open, stretch_done;
    int         gap, first_ren_cyc, last_xfer_cyc, done_cnt;
    int         v_excl = 0, v_busy_read = 0, v_full_read = 0, v_stable = 0;
    int         v_done_busy = 0, v_spacing;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input int unsigned a);
        return 8'((a * 32'd131) ^ (a >> 5) ^ (a >> 13));
    endfunction

    task automatic model_clear();
        wlog.delete();
        rx.delete();
        col = 0; flash_base = 0; addr_done = 1'b0; gap_open = 1'b0; gap = 0;
        rb_timer = 0; done_cnt = 0; f_rb = 1'b1; hold_prev = 1'b0; v_spacing = 0;
        low_run = 0; stretch_done = 1'b0; first_ren_cyc = 0; last_xfer_cyc = 0;
    endtask

    // one clock of the flash device, the consumer and the protocol monitors
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!f_wen && !f_ren) v_excl++;
        if (!f_ren && !f_rb) v_busy_read++;
        if (!f_ren && out_valid) v_full_read++;
        if (done) begin
            done_cnt++;
            if (busy) v_done_busy++;
        end
        if (gap_open) begin
            if (!f_ren) begin
                gap_open = 1'b0;
                first_ren_cyc = cyc;
            end else begin
                gap++;
            end
        end
        if (addr_done) begin
            rb_timer++;
            if (rb_mode == 0) f_rb = !(rb_timer > rb_delay && rb_timer <= rb_delay + rb_len);
            else f_rb = 1'b1;
        end
        if (f_wen && !prev_wen) begin
            wlog.push_back({f_cle, f_ale, f_io_out});
            if (wlog.size() == 4) begin
                addr_done = 1'b1; rb_timer = 0; gap = 0; gap_open = 1'b1;
                flash_base = int'({wlog[3][0], wlog[2][7:0]}) * PAGE_BYTES;
            end
        end
        if (f_ren && !prev_ren) col++;
        f_io_in = mem_byte(flash_base + col);
        if (hold_prev && (!out_valid || out_data !== held)) v_stable++;
        if (ready_mode == 0) begin
            out_ready = 1'b1;
        end else if (low_run > 0) begin
            out_ready = 1'b0;
            low_run--;
        end else if (!stretch_done && rx.size() == 40) begin
            out_ready = 1'b0;
            low_run = 19;
            stretch_done = 1'b1;
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
        if (out_valid && out_ready) begin
            if (ready_mode == 0 && rx.size() > 0 && cyc - last_xfer_cyc != 3) v_spacing++;
            rx.push_back(out_data);
            last_xfer_cyc = cyc;
        end
        hold_prev = out_valid && !out_ready;
        held = out_data;
        prev_wen = f_wen;
        prev_ren = f_ren;
    endtask

    task automatic run_read(input logic [8:0] p, input int rbm, input int dly, input int rdm,
                            input bit poke);
        bit got;
        int bad;
        logic [9:0] exp_w[4];
        model_clear();
        rb_mode = rbm; rb_delay = dly; rb_len = $urandom_range(1, 10); ready_mode = rdm;
        page = p; start = 1'b1;
        tick();
        start = 1'b0;
        check_value("busy_after_start", 32'(busy), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            if (poke) begin
                start = (i == 30 || i == 700);
                if (i > 2) page = 9'($urandom);
            end
            tick();
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check_value("done_seen", 32'(got), 32'd1);
        if (poke && got) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 6; i++) tick();
        check_value("done_count", 32'(done_cnt), 32'd1);
        check_value("busy_after_done", 32'(busy), 32'd0);
        check_value("idle_levels", 32'({f_wen, f_ren, f_cle, f_ale, f_io_oe}), 32'b11000);
        exp_w[0] = {1'b1, 1'b0, 8'h00};
        exp_w[1] = {1'b0, 1'b1, 8'h00};
        exp_w[2] = {1'b0, 1'b1, p[7:0]};
        exp_w[3] = {1'b0, 1'b1, 7'b0000000, p[8]};
        check_value("write_count", 32'(wlog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < wlog.size()) check_value($sformatf("write%0d", k), 32'(wlog[k]), 32'(exp_w[k]));
        check_value("rx_count", 32'(rx.size()), 32'(PAGE_BYTES));
        bad = 0;
        foreach (rx[i]) if (rx[i] !== mem_byte(int'(p) * PAGE_BYTES + i)) bad++;
        check_value("rx_bytes_bad", 32'(bad), 32'd0);
        if (rdm == 0) begin
            check_value("xfer_spacing_bad", 32'(v_spacing), 32'd0);
            check_value("read_phase_len", 32'(last_xfer_cyc - first_ren_cyc + 1), 32'(3 * PAGE_BYTES));
        end
        if (rbm == 1)
            check_value("bsy_timeout_gap_ok", 32'(gap >= BSY_TO && gap <= BSY_TO + 2), 32'd1);
    endtask

    initial begin
        bit reached;
        rst = 1'b1; start = 1'b0; page = 9'd0; out_ready = 1'b0; f_rb = 1'b1; f_io_in = 8'h00;
        prev_wen = 1'b1; prev_ren = 1'b1; cyc = 0; ready_mode = 0; rb_mode = 0;
        model_clear();
        for (int i = 0; i < 3; i++) tick();
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_wen_ren", 32'({f_wen, f_ren}), 32'b11);
        check_value("rst_outputs",
                    32'({done, out_valid, out_data, f_io_out, f_io_oe, f_cle, f_ale}), 32'd0);
        rst = 1'b0;
        tick();

        run_read(9'h105, 0, 3, 0, 1'b0);
        run_read(9'($urandom), 0, $urandom_range(0, 5), 1, 1'b0);
        run_read(9'($urandom), 1, 0, 1, 1'b0);
        run_read(9'h1FF, 1, 0, 0, 1'b0);
        run_read(9'($urandom), 0, $urandom_range(0, 5), 1, 1'b1);

        // abort mid-read, then a fresh read of page 0
        model_clear();
        rb_mode = 0; rb_delay = 2; rb_len = 4; ready_mode = 1;
        page = 9'($urandom); start = 1'b1;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 5000 && !reached; i++) begin
            tick();
            if (rx.size() >= 100) reached = 1'b1;
        end
        check_value("abort_point_reached", 32'(reached), 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_value("abort_rst_state",
                    32'({busy, done, out_valid, out_data, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren}),
                    32'b11);
        for (int i = 0; i < 5; i++) tick();
        check_value("no_done_after_abort", 32'(done_cnt), 32'd0);
        run_read(9'd0, 0, $urandom_range(0, 5), 1, 1'b0);

        check_value("wen_ren_overlap", 32'(v_excl), 32'd0);
        check_value("read_while_rb_low", 32'(v_busy_read), 32'd0);
        check_value("read_while_full", 32'(v_full_read), 32'd0);
        check_value("hold_unstable", 32'(v_stable), 32'd0);
        check_value("done_with_busy", 32'(v_done_busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
